// File: rtl/lcd_rgb_rx.sv
// lcd_rgb_rx: receiver for a DE-mode RGB565 LCD pixel stream.
//
// HS/VS are unused in DE mode, so frame boundaries come from long DE-low
// runs: any DE-low run of at least VGAP_MIN clocks is vertical blanking.
// Outputs are the recovered pixel stream with coordinates, line/frame strobes,
// the measured timing and a lock/error status.
//
// Ports
//   lcd_clk        pixel clock, all logic on the rising edge
//   sys_rst_n      asynchronous active-low reset
//   lcd_de         data enable from the panel interface
//   lcd_rgb[15:0]  RGB565 pixel, meaningful while lcd_de=1
//   pixel_data     registered pixel (0 while pixel_valid=0)
//   pixel_valid    pixel_data/pixel_xpos/pixel_ypos are valid
//   pixel_xpos     0-based column, saturating at 2047
//   pixel_ypos     0-based row, saturating at 2047
//   frame_start    pulse with pixel (0,0)
//   line_end       pulse one cycle after the last DE-high sample of a line
//   frame_end      pulse when the DE-low run reaches VGAP_MIN inside a frame
//   h_active       DE-high length of the last completed line
//   h_total        DE rise-to-rise distance within the current frame
//   v_active       line count of the last completed frame
//   timing_locked  LOCK_FRAMES consecutive good frames seen
//   timing_err     sticky bad-frame flag, cleared by reset only
//
// Pixel outputs lag the pins by exactly two clocks (input register plus
// output register).
module lcd_rgb_rx #(
    parameter logic [10:0] H_DISP      = 11'd480,
    parameter logic [10:0] V_DISP      = 11'd272,
    parameter logic [15:0] VGAP_MIN    = 16'd1024,
    parameter logic [1:0]  LOCK_FRAMES = 2'd2
) (
    input  logic        lcd_clk,
    input  logic        sys_rst_n,
    input  logic        lcd_de,
    input  logic [15:0] lcd_rgb,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        frame_start,
    output logic        line_end,
    output logic        frame_end,
    output logic [10:0] h_active,
    output logic [15:0] h_total,
    output logic [10:0] v_active,
    output logic        timing_locked,
    output logic        timing_err
);

    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,
        ARMED    = 2'd1,
        IN_FRAME = 2'd2
    } state_e;

    function automatic logic [10:0] sat_inc11(input logic [10:0] v);
        return (v == 11'h7FF) ? v : v + 11'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [1:0] sat_inc2(input logic [1:0] v);
        return (v == 2'd3) ? v : v + 2'd1;
    endfunction

    // input stage
    logic        de_d1_q, de_d2_q;
    logic [15:0] rgb_d1_q;

    // detection / tracking state
    state_e      state_q, state_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [10:0] x_q, x_d;
    logic [10:0] y_q, y_d;
    logic [10:0] run_q, run_d;     // DE-high length of the current line
    logic [15:0] rr_q, rr_d;       // clocks since the last DE rise
    logic        bad_q, bad_d;     // current frame already known bad
    logic [1:0]  good_q, good_d;   // consecutive good frames

    // registered outputs
    logic [15:0] pix_data_q, pix_data_d;
    logic        pix_valid_q, pix_valid_d;
    logic [10:0] pix_x_q, pix_x_d;
    logic [10:0] pix_y_q, pix_y_d;
    logic        fs_q, fs_d;
    logic        le_q, le_d;
    logic        fe_q, fe_d;
    logic [10:0] h_active_q, h_active_d;
    logic [15:0] h_total_q, h_total_d;
    logic [10:0] v_active_q, v_active_d;
    logic        locked_q, locked_d;
    logic        err_q, err_d;

    logic        rise, fall;
    logic [10:0] lines_seen;

    assign rise       = de_d1_q & ~de_d2_q;
    assign fall       = ~de_d1_q & de_d2_q;
    assign lines_seen = sat_inc11(y_q);

    always_comb begin
        gap_cnt_d   = de_d1_q ? 16'd0 : sat_inc16(gap_cnt_q);
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        run_d       = run_q;
        rr_d        = sat_inc16(rr_q);
        bad_d       = bad_q;
        good_d      = good_q;
        h_active_d  = h_active_q;
        h_total_d   = h_total_q;
        v_active_d  = v_active_q;
        err_d       = err_q;
        pix_valid_d = 1'b0;
        fs_d        = 1'b0;
        le_d        = 1'b0;
        fe_d        = 1'b0;

        case (state_q)
            WAIT_GAP: begin
                // Only a full vertical gap proves we are between frames.
                if (gap_cnt_d >= VGAP_MIN) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (rise) begin
                    state_d     = IN_FRAME;
                    x_d         = 11'd0;
                    y_d         = 11'd0;
                    run_d       = 11'd1;
                    rr_d        = 16'd1;
                    bad_d       = 1'b0;
                    pix_valid_d = 1'b1;
                    fs_d        = 1'b1;
                end
            end
            IN_FRAME: begin
                if (rise) begin
                    h_total_d   = rr_q;
                    rr_d        = 16'd1;
                    x_d         = 11'd0;
                    y_d         = sat_inc11(y_q);
                    run_d       = 11'd1;
                    pix_valid_d = 1'b1;
                end else if (de_d1_q) begin
                    x_d         = sat_inc11(x_q);
                    run_d       = sat_inc11(run_q);
                    pix_valid_d = 1'b1;
                end

                if (fall) begin
                    le_d       = 1'b1;
                    h_active_d = run_q;
                    // A wrong-width line drops lock straight away.
                    if (run_q != H_DISP) begin
                        bad_d  = 1'b1;
                        good_d = 2'd0;
                    end
                end

                // gap_cnt_d is nonzero here, so this never coincides with a rise.
                if (gap_cnt_d == VGAP_MIN) begin
                    fe_d       = 1'b1;
                    v_active_d = lines_seen;
                    state_d    = ARMED;
                    if (bad_d || (lines_seen != V_DISP)) begin
                        good_d = 2'd0;
                        err_d  = 1'b1;
                    end else begin
                        good_d = sat_inc2(good_q);
                    end
                end
            end
            default: state_d = WAIT_GAP;
        endcase

        locked_d   = (good_d >= LOCK_FRAMES);
        pix_data_d = pix_valid_d ? rgb_d1_q : 16'd0;
        pix_x_d    = pix_valid_d ? x_d : 11'd0;
        pix_y_d    = pix_valid_d ? y_d : 11'd0;
    end

    always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            de_d1_q     <= 1'b0;
            de_d2_q     <= 1'b0;
            rgb_d1_q    <= 16'd0;
            state_q     <= WAIT_GAP;
            gap_cnt_q   <= 16'd0;
            x_q         <= 11'd0;
            y_q         <= 11'd0;
            run_q       <= 11'd0;
            rr_q        <= 16'd0;
            bad_q       <= 1'b0;
            good_q      <= 2'd0;
            pix_data_q  <= 16'd0;
            pix_valid_q <= 1'b0;
            pix_x_q     <= 11'd0;
            pix_y_q     <= 11'd0;
            fs_q        <= 1'b0;
            le_q        <= 1'b0;
            fe_q        <= 1'b0;
            h_active_q  <= 11'd0;
            h_total_q   <= 16'd0;
            v_active_q  <= 11'd0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            de_d1_q     <= lcd_de;
            de_d2_q     <= de_d1_q;
            rgb_d1_q    <= lcd_rgb;
            state_q     <= state_d;
            gap_cnt_q   <= gap_cnt_d;
            x_q         <= x_d;
            y_q         <= y_d;
            run_q       <= run_d;
            rr_q        <= rr_d;
            bad_q       <= bad_d;
            good_q      <= good_d;
            pix_data_q  <= pix_data_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q     <= pix_x_d;
            pix_y_q     <= pix_y_d;
            fs_q        <= fs_d;
            le_q        <= le_d;
            fe_q        <= fe_d;
            h_active_q  <= h_active_d;
            h_total_q   <= h_total_d;
            v_active_q  <= v_active_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
        end
    end

    assign pixel_data    = pix_data_q;
    assign pixel_valid   = pix_valid_q;
    assign pixel_xpos    = pix_x_q;
    assign pixel_ypos    = pix_y_q;
    assign frame_start   = fs_q;
    assign line_end      = le_q;
    assign frame_end     = fe_q;
    assign h_active      = h_active_q;
    assign h_total       = h_total_q;
    assign v_active      = v_active_q;
    assign timing_locked = locked_q;
    assign timing_err    = err_q;

endmodule
